cpu_move_responder: RTL and testbench
=====================================

Name: cpu_move_responder

Overview:
- Answers the game FSM's CPU-turn request with a legal move.
- The game FSM sends a request carrying a snapshot of the 3x3 board. This block scans the snapshot sequentially and returns one (x, y) cell over a valid/ready handshake.
- Move priority: winning move, then block the player's winning move, then positional preference.
- Sits beside the game FSM; it is the responder end of the CPU-turn interface.

Parameters:
- EMPTY_CODE, 2'b00, cell code for an empty cell
- PLAYER_CODE, 2'b01, cell code for a player mark
- CPU_CODE, 2'b10, cell code for a CPU mark

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- req_valid  input  1  game FSM presents a board for a CPU move
- req_ready  output  1  responder can accept a request
- req_board  input  18  cell i in bits [2i+1:2i]; i = 3*row + col
- resp_valid  output  1  move result available
- resp_ready  input  1  game FSM consumes the result
- move_x  output  2  chosen column, 0..2
- move_y  output  2  chosen row, 0..2
- resp_none  output  1  board full, no legal move

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-low: sampled on the rising edge of clock while reset == 0.
- Reset state:
  - state = IDLE, req_ready = 1, resp_valid = 0.
  - move_x = 0, move_y = 0, resp_none = 0.
  - Scan index = 0; board snapshot cleared.
- Reset mid-operation:
  - Any in-flight scan or pending response is discarded; the block returns to the reset state.
- Cell codes:
  - Cell code 2'b11 counts as occupied by neither side: never chosen, never counted toward a line.
- Line table, evaluated in this order:
  - 0: cells 0,1,2
  - 1: cells 3,4,5
  - 2: cells 6,7,8
  - 3: cells 0,3,6
  - 4: cells 1,4,7
  - 5: cells 2,5,8
  - 6: cells 0,4,8
  - 7: cells 2,4,6
- Preference order (index 0..8): cells 4, 0, 2, 6, 8, 1, 3, 5, 7.
- States: IDLE, SCAN_WIN, SCAN_BLOCK, SCAN_PREF, RESP.
- IDLE:
  - req_ready = 1 only in IDLE.
  - On req_valid & req_ready: latch req_board, set index = 0, go to SCAN_WIN.
- SCAN_WIN, one line per clock edge:
  - If the line holds exactly two CPU_CODE cells and one EMPTY_CODE cell: set move_x/move_y to the empty cell, resp_none = 0, go to RESP.
  - Otherwise index++.
  - After line 7: index = 0, go to SCAN_BLOCK.
- SCAN_BLOCK: same rule as SCAN_WIN with PLAYER_CODE; after line 7: index = 0, go to SCAN_PREF.
- SCAN_PREF:
  - One preference entry per edge; the first EMPTY_CODE cell is chosen, go to RESP.
  - After entry 8 with none empty: resp_none = 1, move_x = move_y = 0, go to RESP.
- RESP:
  - resp_valid = 1.
  - move_x, move_y and resp_none are held stable while resp_ready = 0.
  - On resp_valid & resp_ready: resp_valid drops and state returns to IDLE on that edge. req_ready = 1 in the following cycle.
  - Requests arriving while not in IDLE are ignored (no acceptance).
- Latency, counted in edges after the accept edge until resp_valid is high:
  - Win found at line k: k+1.
  - Block found at line k: 9+k.
  - Preference hit at position p: 17+p.
  - Full board: 26.
- Simultaneous events:
  - Several winning lines: the lowest line index wins.
  - A win and a block both exist: the win has priority.
- Output timing: all outputs are registered; no combinational path from req_* to resp_*.

Test Plan:
- CPU at cells 0,1; player at 3,4; accept -> after 1 edge resp_valid = 1, move_x = 2, move_y = 0, resp_none = 0.
- Player at 0,4; CPU at 1; no CPU win -> block on line 6: resp_valid after 15 edges, move_x = 2, move_y = 2.
- All cells empty -> resp_valid after 17 edges, move_x = 1, move_y = 1.
- Full board with no empty cell (includes 2'b11 cells) -> resp_valid after 26 edges, resp_none = 1, move = (0,0).
- Backpressure: hold resp_ready = 0 for 5 cycles in RESP while pulsing req_valid -> outputs stable, req_ready = 0, no new accept. Then resp_ready = 1 -> resp_valid = 0 and req_ready = 1 the next cycle.
- Reset mid-operation: reset = 0 for one edge during SCAN_BLOCK -> resp_valid = 0, req_ready = 1, move = (0,0). A new request then behaves exactly as from power-up.

Source files
------------

// File: rtl/cpu_move_responder.sv
// cpu_move_responder: picks a CPU tic-tac-toe move (win, block, preference) over valid/ready
module cpu_move_responder #(
  parameter logic [1:0] EMPTY_CODE  = 2'b00,
  parameter logic [1:0] PLAYER_CODE = 2'b01,
  parameter logic [1:0] CPU_CODE    = 2'b10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [17:0] req_board,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [1:0]  move_x,
  output logic [1:0]  move_y,
  output logic        resp_none
);
  typedef enum logic [2:0] {IDLE, SCAN_WIN, SCAN_BLOCK, SCAN_PREF, RESP} state_t;
  // Line k occupies bits [12k+11:12k] as three 4-bit cell indices; line 0 is the low slice.
  localparam logic [95:0] LINES = {
    4'd2, 4'd4, 4'd6,
    4'd0, 4'd4, 4'd8,
    4'd2, 4'd5, 4'd8,
    4'd1, 4'd4, 4'd7,
    4'd0, 4'd3, 4'd6,
    4'd6, 4'd7, 4'd8,
    4'd3, 4'd4, 4'd5,
    4'd0, 4'd1, 4'd2
  };
  // Preference entry p at bits [4p+3:4p]; the top nibble pads index 9, the give-up step.
  localparam logic [39:0] PREF = {4'd0, 4'd7, 4'd5, 4'd3, 4'd1, 4'd8, 4'd6, 4'd2, 4'd0, 4'd4};
  state_t      state;
  logic [3:0]  idx;
  logic [17:0] board;
  logic [11:0] cells;
  logic [3:0]  a, b, c, empty_cell, pref_cell, pick;
  logic [1:0]  ca, cb, cc, side, n_side, n_empty, pick_x, pick_y;
  logic        line_hit, pref_hit;
  // Evaluate the line or preference entry selected by the scan index.
  always_comb begin
    cells      = LINES[idx[2:0]*12 +: 12];
    a          = cells[11:8];
    b          = cells[7:4];
    c          = cells[3:0];
    ca         = board[a*2 +: 2];
    cb         = board[b*2 +: 2];
    cc         = board[c*2 +: 2];
    side       = state == SCAN_WIN ? CPU_CODE : PLAYER_CODE;
    n_side     = 2'(ca == side) + 2'(cb == side) + 2'(cc == side);
    n_empty    = 2'(ca == EMPTY_CODE) + 2'(cb == EMPTY_CODE) + 2'(cc == EMPTY_CODE);
    line_hit   = n_side == 2'd2 && n_empty == 2'd1;
    empty_cell = ca == EMPTY_CODE ? a : cb == EMPTY_CODE ? b : c;
    pref_cell  = PREF[idx*4 +: 4];
    pref_hit   = board[pref_cell*2 +: 2] == EMPTY_CODE;
    pick       = state == SCAN_PREF ? pref_cell : empty_cell;
    pick_x     = 2'(pick % 4'd3);
    pick_y     = 2'(pick / 4'd3);
  end
  // Scan sequencer with registered handshake and move outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      board      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      move_x     <= '0;
      move_y     <= '0;
      resp_none  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          board     <= req_board;
          idx       <= '0;
          req_ready <= 1'b0;
          state     <= SCAN_WIN;
        end
        SCAN_WIN, SCAN_BLOCK: if (line_hit) begin
          move_x     <= pick_x;
          move_y     <= pick_y;
          resp_none  <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end else if (idx == 4'd7) begin
          idx   <= '0;
          state <= state == SCAN_WIN ? SCAN_BLOCK : SCAN_PREF;
        end else idx <= idx + 4'd1;
        SCAN_PREF: if (idx == 4'd9) begin
          move_x     <= '0;
          move_y     <= '0;
          resp_none  <= 1'b1;
          resp_valid <= 1'b1;
          state      <= RESP;
        end else if (pref_hit) begin
          move_x     <= pick_x;
          move_y     <= pick_y;
          resp_none  <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end else idx <= idx + 4'd1;
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_move_responder.sv
// tb_cpu_move_responder: directed checks of move choice, latency, backpressure and reset
module tb_cpu_move_responder;
  localparam logic [1:0] E = 2'b00, P = 2'b01, C = 2'b10, X = 2'b11;
  logic        clock = 0, reset = 0, req_valid = 0, resp_ready = 0;
  logic [17:0] req_board = '0;
  logic        req_ready, resp_valid, resp_none;
  logic [1:0]  move_x, move_y;
  int          passed = 0, total = 0;
  cpu_move_responder dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_board(req_board), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .move_x(move_x), .move_y(move_y), .resp_none(resp_none)
  );
  always #5 clock = ~clock;
  // Compare one observed value against its hand-computed expectation.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else passed++;
  endtask
  function automatic logic [17:0] bd(input logic [1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction
  // Issue one request and check latency and the returned move; leaves the response pending.
  task automatic run(input string tag, input logic [17:0] b, input int lat, input int x, input int y, input int none);
    int n;
    @(negedge clock);
    req_board = b;
    req_valid = 1;
    @(posedge clock);
    #1 req_valid = 0;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(posedge clock);
      #1 n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_x"}, move_x, x);
    check({tag, "_y"}, move_y, y);
    check({tag, "_none"}, resp_none, none);
  endtask
  task automatic consume(input string tag);
    @(negedge clock);
    resp_ready = 1;
    @(posedge clock);
    #1 resp_ready = 0;
    check({tag, "_done_valid"}, resp_valid, 0);
    check({tag, "_done_ready"}, req_ready, 1);
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_move", {move_x, move_y}, 0);
    check("rst_none", resp_none, 0);
    @(negedge clock);
    reset = 1;
    run("win", bd(C, C, E, P, P, E, E, E, E), 1, 2, 0, 0);
    consume("win");
    run("block", bd(P, C, E, E, P, E, E, E, E), 15, 2, 2, 0);
    consume("block");
    run("empty", '0, 17, 1, 1, 0);
    consume("empty");
    run("full", bd(P, C, P, C, P, X, C, P, C), 26, 0, 0, 1);
    consume("full");
    run("win_over_block", bd(P, P, E, C, C, E, E, E, E), 2, 2, 1, 0);
    consume("win_over_block");
    run("pref1", bd(E, E, E, E, P, E, E, E, E), 18, 0, 0, 0);
    consume("pref1");
    run("skip11", bd(X, E, E, E, X, E, E, E, E), 19, 2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      req_valid = i[0];
      req_board = '0;
      @(posedge clock);
      #1;
      check("bp_valid", resp_valid, 1);
      check("bp_req_ready", req_ready, 0);
      check("bp_move", {move_x, move_y}, {2'd2, 2'd0});
    end
    req_valid = 0;
    consume("bp");
    @(negedge clock);
    req_board = '0;
    req_valid = 1;
    @(posedge clock);
    #1 req_valid = 0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 0;
    @(posedge clock);
    #1;
    check("mid_rst_valid", resp_valid, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_move", {move_x, move_y}, 0);
    @(negedge clock);
    reset = 1;
    repeat (3) @(posedge clock);
    #1 check("mid_rst_idle_valid", resp_valid, 0);
    run("after_rst", bd(C, C, E, P, P, E, E, E, E), 1, 2, 0, 0);
    consume("after_rst");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
